// File: rtl/mem_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_pkg
//   Shared types for the instruction/data memory bus arbiter.
//   - u1 / u64        : common scalar and 64-bit word types
//   - msize_t         : access size encoding carried on the memory bus
//   - mem_arb_state_t : arbiter FSM state encoding
//   - WAIT_W          : width of the busy-cycle watchdog counter
//   - select_word()   : picks the 32-bit instruction word out of a 64-bit beat
// -----------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

    typedef logic        u1;
    typedef logic [63:0] u64;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFETCH = 2'd1,
        DMEM   = 2'd2
    } mem_arb_state_t;

    localparam int WAIT_W = 8;

    // Instructions are 4 bytes inside an 8-byte bus beat; address bit 2
    // selects which half of the beat holds the requested word.
    function automatic logic [31:0] select_word(input u64 beat, input u1 upper_half);
        return upper_half ? beat[63:32] : beat[31:0];
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//   Arbitrates a single shared memory bus between the fetch stage (ireq_*) and
//   the memory stage (dreq_*). Data requests have strict priority. A granted
//   request is latched and the bus is driven only from the latched copy, so the
//   pipeline may change its request inputs while the access is in flight.
//   Every access is followed by one IDLE cycle before the next grant.
//
// Parameters
//   TIMEOUT      : busy cycles without mresp_valid before the access is
//                  abandoned and bus_err is raised (1..255)
//
// Ports
//   clk, reset           : clock, asynchronous active-high reset
//   ireq_valid/addr      : instruction fetch request (held until response/flush)
//   iresp_valid/data     : one-cycle instruction response, 32-bit word
//   dreq_valid/write/size/strobe/addr/wdata : data request (held until response)
//   dresp_valid/rdata    : one-cycle data response, 64-bit read data
//   mreq_valid/write/size/strobe/addr/wdata : shared bus request (registered)
//   mresp_valid/data     : shared bus completion and read data
//   stall_all            : freeze every pipeline register
//   stall_fetch          : freeze the fetch/decode register
//   flush                : branch redirect; kills a pending or in-flight fetch
//   bus_err              : sticky watchdog flag, cleared only by reset
// -----------------------------------------------------------------------------
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        ireq_valid,
    input  logic [63:0] ireq_addr,
    output logic        iresp_valid,
    output logic [31:0] iresp_data,

    input  logic        dreq_valid,
    input  logic        dreq_write,
    input  logic [2:0]  dreq_size,
    input  logic [7:0]  dreq_strobe,
    input  logic [63:0] dreq_addr,
    input  logic [63:0] dreq_wdata,
    output logic        dresp_valid,
    output logic [63:0] dresp_rdata,

    output logic        mreq_valid,
    output logic        mreq_write,
    output logic [2:0]  mreq_size,
    output logic [7:0]  mreq_strobe,
    output logic [63:0] mreq_addr,
    output logic [63:0] mreq_wdata,
    input  logic        mresp_valid,
    input  logic [63:0] mresp_data,

    output logic        stall_all,
    output logic        stall_fetch,
    input  logic        flush,
    output logic        bus_err
);

    localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);

    mem_arb_state_t    state_reg,    state_next;
    logic              write_reg,    write_next;
    msize_t            size_reg,     size_next;
    logic [7:0]        strobe_reg,   strobe_next;
    logic [63:0]       addr_reg,     addr_next;
    logic [63:0]       wdata_reg,    wdata_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              discard_reg,  discard_next;
    logic              bus_err_reg,  bus_err_next;

    logic [WAIT_W-1:0] wait_inc;
    logic              iresp_hit;
    logic              dresp_hit;

    assign wait_inc = wait_cnt_reg + WAIT_W'(1);

    // ---------------------------------------------------------------------
    // Next-state logic: grants, request latching, watchdog, discard tracking
    // ---------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        write_next    = write_reg;
        size_next     = size_reg;
        strobe_next   = strobe_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        wait_cnt_next = wait_cnt_reg;
        discard_next  = discard_reg;
        bus_err_next  = bus_err_reg;

        unique case (state_reg)
            IDLE: begin
                // mresp_valid is deliberately ignored here.
                if (dreq_valid) begin
                    state_next    = DMEM;
                    write_next    = dreq_write;
                    size_next     = msize_t'(dreq_size);
                    strobe_next   = dreq_strobe;
                    addr_next     = dreq_addr;
                    wdata_next    = dreq_wdata;
                    wait_cnt_next = '0;
                end else if (ireq_valid && !flush) begin
                    // A redirect in the same cycle makes this address stale,
                    // so the fetch is only granted without a flush.
                    state_next    = IFETCH;
                    write_next    = 1'b0;
                    size_next     = MSIZE4;
                    strobe_next   = 8'h00;
                    addr_next     = ireq_addr;
                    wdata_next    = 64'h0;
                    wait_cnt_next = '0;
                end
            end

            IFETCH, DMEM: begin
                if (mresp_valid) begin
                    state_next   = IDLE;
                    discard_next = 1'b0;
                end else begin
                    wait_cnt_next = wait_inc;
                    if (wait_inc == TIMEOUT_CNT) begin
                        // Abandon the access; no response pulse is produced.
                        state_next   = IDLE;
                        bus_err_next = 1'b1;
                        discard_next = 1'b0;
                    end else if (state_reg == IFETCH && flush) begin
                        // The bus beat must still complete, but its data is
                        // for a wrong-path fetch and must not be delivered.
                        discard_next = 1'b1;
                    end
                end
            end

            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // State and latched request registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            write_reg    <= 1'b0;
            size_reg     <= MSIZE1;
            strobe_reg   <= 8'h00;
            addr_reg     <= 64'h0;
            wdata_reg    <= 64'h0;
            wait_cnt_reg <= '0;
            discard_reg  <= 1'b0;
            bus_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            write_reg    <= write_next;
            size_reg     <= size_next;
            strobe_reg   <= strobe_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            wait_cnt_reg <= wait_cnt_next;
            discard_reg  <= discard_next;
            bus_err_reg  <= bus_err_next;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs: bus side comes from the latched copy, responses pass through
    // combinationally in the completion cycle.
    // ---------------------------------------------------------------------
    always_comb begin
        dresp_hit = (state_reg == DMEM) && mresp_valid;
        iresp_hit = (state_reg == IFETCH) && mresp_valid && !discard_reg && !flush;

        mreq_valid  = (state_reg != IDLE);
        mreq_write  = write_reg;
        mreq_size   = size_reg;
        mreq_strobe = strobe_reg;
        mreq_addr   = addr_reg;
        mreq_wdata  = wdata_reg;

        dresp_valid = dresp_hit;
        dresp_rdata = mresp_data;
        iresp_valid = iresp_hit;
        iresp_data  = select_word(mresp_data, addr_reg[2]);

        stall_all   = dreq_valid && !dresp_hit;
        stall_fetch = (dreq_valid && !dresp_hit) || (ireq_valid && !iresp_hit && !flush);
        bus_err     = bus_err_reg;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ireq_valid = 1'b0;
    logic [63:0] ireq_addr = '0;
    logic        iresp_valid;
    logic [31:0] iresp_data;
    logic        dreq_valid = 1'b0;
    logic        dreq_write = 1'b0;
    logic [2:0]  dreq_size = '0;
    logic [7:0]  dreq_strobe = '0;
    logic [63:0] dreq_addr = '0;
    logic [63:0] dreq_wdata = '0;
    logic        dresp_valid;
    logic [63:0] dresp_rdata;
    logic        mreq_valid;
    logic        mreq_write;
    logic [2:0]  mreq_size;
    logic [7:0]  mreq_strobe;
    logic [63:0] mreq_addr;
    logic [63:0] mreq_wdata;
    logic        mresp_valid = 1'b0;
    logic [63:0] mresp_data = '0;
    logic        stall_all;
    logic        stall_fetch;
    logic        flush = 1'b0;
    logic        bus_err;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_valid(iresp_valid), .iresp_data(iresp_data),
        .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_addr(dreq_addr), .dreq_wdata(dreq_wdata),
        .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata),
        .mreq_valid(mreq_valid), .mreq_write(mreq_write), .mreq_size(mreq_size),
        .mreq_strobe(mreq_strobe), .mreq_addr(mreq_addr), .mreq_wdata(mreq_wdata),
        .mresp_valid(mresp_valid), .mresp_data(mresp_data),
        .stall_all(stall_all), .stall_fetch(stall_fetch),
        .flush(flush), .bus_err(bus_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        ireq_valid = 0; ireq_addr = '0; flush = 0;
        dreq_valid = 0; dreq_write = 0; dreq_size = 3'(MSIZE8); dreq_strobe = 8'hFF;
        dreq_addr = '0; dreq_wdata = '0;
        mresp_valid = 0; mresp_data = '0;
    endtask

    // ---------------- table-driven vectors ----------------
    typedef struct {
        logic        iv;  logic [63:0] ia;
        logic        dv;  logic [63:0] da;
        logic        mv;  logic [63:0] md;
        logic        fl;
        logic        e_mv; logic [63:0] e_maddr;
        logic        e_iv; logic [31:0] e_id;
        logic        e_dv; logic e_sa; logic e_sf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic iv, input logic [63:0] ia, input logic dv,
                                input logic [63:0] da, input logic mv, input logic [63:0] md,
                                input logic fl, input logic e_mv, input logic [63:0] e_maddr,
                                input logic e_iv, input logic [31:0] e_id, input logic e_dv,
                                input logic e_sa, input logic e_sf);
        vec_t v;
        v.iv = iv; v.ia = ia; v.dv = dv; v.da = da; v.mv = mv; v.md = md; v.fl = fl;
        v.e_mv = e_mv; v.e_maddr = e_maddr; v.e_iv = e_iv; v.e_id = e_id;
        v.e_dv = e_dv; v.e_sa = e_sa; v.e_sf = e_sf;
        return v;
    endfunction

    task automatic apply_row(input vec_t v, input int idx);
        clear_inputs();
        ireq_valid = v.iv; ireq_addr = v.ia;
        dreq_valid = v.dv; dreq_addr = v.da;
        mresp_valid = v.mv; mresp_data = v.md; flush = v.fl;
        #1;
        check($sformatf("row%0d mreq_valid", idx), mreq_valid, v.e_mv);
        check($sformatf("row%0d mreq_addr", idx), mreq_addr, v.e_maddr);
        check($sformatf("row%0d iresp_valid", idx), iresp_valid, v.e_iv);
        if (v.e_iv) check($sformatf("row%0d iresp_data", idx), iresp_data, v.e_id);
        check($sformatf("row%0d dresp_valid", idx), dresp_valid, v.e_dv);
        if (v.e_dv) check($sformatf("row%0d dresp_rdata", idx), dresp_rdata, v.md);
        check($sformatf("row%0d stall_all", idx), stall_all, v.e_sa);
        check($sformatf("row%0d stall_fetch", idx), stall_fetch, v.e_sf);
        check($sformatf("row%0d bus_err", idx), bus_err, 1'b0);
        if (v.e_iv) $display("row%0d ifetch addr=0x%0h data=0x%08h", idx, v.ia, iresp_data);
        if (v.e_dv) $display("row%0d dmem addr=0x%0h rdata=0x%016h", idx, v.da, dresp_rdata);
    endtask

    // ---------------- behavioural reference model ----------------
    // Tracks the in-flight transaction (0 none, 1 fetch, 2 data), its bus
    // fields, how long it has waited, and whether its data is to be dropped.
    int          m_kind;
    logic        m_wr;
    logic [2:0]  m_size;
    logic [7:0]  m_strb;
    logic [63:0] m_addr, m_wdata;
    int          m_waited;
    bit          m_dropped, m_err;

    task automatic model_reset();
        m_kind = 0; m_wr = 0; m_size = '0; m_strb = '0; m_addr = '0; m_wdata = '0;
        m_waited = 0; m_dropped = 0; m_err = 0;
    endtask

    task automatic model_step();
        if (m_kind == 0) begin
            if (dreq_valid) begin
                m_kind = 2; m_addr = dreq_addr; m_wr = dreq_write; m_size = dreq_size;
                m_strb = dreq_strobe; m_wdata = dreq_wdata; m_waited = 0;
            end else if (ireq_valid && !flush) begin
                m_kind = 1; m_addr = ireq_addr; m_wr = 0; m_size = 3'(MSIZE4);
                m_strb = 0; m_wdata = 0; m_waited = 0;
            end
        end else if (mresp_valid) begin
            m_kind = 0; m_dropped = 0;
        end else begin
            m_waited++;
            if (m_waited >= TIMEOUT) begin
                $display("txn timeout kind=%0d addr=0x%0h", m_kind, m_addr);
                m_kind = 0; m_err = 1; m_dropped = 0;
            end else if (m_kind == 1 && flush) begin
                m_dropped = 1;
            end
        end
    endtask

    initial begin
        bit          i_pend, d_pend;
        logic        e_iv, e_dv, e_sa, e_sf;
        logic [63:0] held_ia;
        logic [63:0] d_addr, d_wdata;
        logic        d_wr;
        logic [2:0]  d_size;
        logic [7:0]  d_strb;

        clear_inputs();
        #1 reset = 1;
        #2;
        // Reset state
        check("reset mreq_valid", mreq_valid, 0);
        check("reset mreq_addr", mreq_addr, 0);
        check("reset mreq_wdata", mreq_wdata, 0);
        check("reset mreq_write", mreq_write, 0);
        check("reset mreq_strobe", mreq_strobe, 0);
        check("reset iresp_valid", iresp_valid, 0);
        check("reset dresp_valid", dresp_valid, 0);
        check("reset stall_all", stall_all, 0);
        check("reset stall_fetch", stall_fetch, 0);
        check("reset bus_err", bus_err, 0);
        repeat (2) @(negedge clk);
        reset = 0;

        // Table: lone fetch, mresp in IDLE, priority, flush, flush-in-IDLE,
        // dreq arriving during fetch.
        tbl.push_back(mk(1,64'h8000_0004,0,0,0,0,0, 0,64'h0,0,0,0,0,1));
        tbl.push_back(mk(1,64'h8000_0004,0,0,0,0,0, 1,64'h8000_0004,0,0,0,0,1));
        tbl.push_back(mk(1,64'h8000_0004,0,0,0,0,0, 1,64'h8000_0004,0,0,0,0,1));
        tbl.push_back(mk(1,64'h8000_0004,0,0,0,0,0, 1,64'h8000_0004,0,0,0,0,1));
        tbl.push_back(mk(1,64'h8000_0004,0,0,1,64'hAABBCCDD_11223344,0, 1,64'h8000_0004,1,32'hAABBCCDD,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,64'h8000_0004,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,64'hFFFF0000_FFFF0000,0, 0,64'h8000_0004,0,0,0,0,0));
        tbl.push_back(mk(1,64'h200,1,64'h100,0,0,0, 0,64'h8000_0004,0,0,0,1,1));
        tbl.push_back(mk(1,64'h200,1,64'h100,0,0,0, 1,64'h100,0,0,0,1,1));
        tbl.push_back(mk(1,64'h200,1,64'h100,1,64'h01234567_89ABCDEF,0, 1,64'h100,0,0,1,0,1));
        tbl.push_back(mk(1,64'h200,0,0,0,0,0, 0,64'h100,0,0,0,0,1));
        tbl.push_back(mk(1,64'h200,0,0,0,0,0, 1,64'h200,0,0,0,0,1));
        tbl.push_back(mk(1,64'h200,0,0,0,0,1, 1,64'h200,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,64'h0BAD0BAD_0BAD0BAD,0, 1,64'h200,0,0,0,0,0));
        tbl.push_back(mk(1,64'h300,0,0,0,0,0, 0,64'h200,0,0,0,0,1));
        tbl.push_back(mk(1,64'h300,0,0,1,64'h55667788_99AABBCC,0, 1,64'h300,1,32'h99AABBCC,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,64'h300,0,0,0,0,0));
        tbl.push_back(mk(1,64'h400,0,0,0,0,1, 0,64'h300,0,0,0,0,0));
        tbl.push_back(mk(1,64'h400,0,0,0,0,0, 0,64'h300,0,0,0,0,1));
        tbl.push_back(mk(1,64'h400,0,0,1,64'hDEADBEEF_CAFEF00D,0, 1,64'h400,1,32'hCAFEF00D,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,64'h400,0,0,0,0,0));
        tbl.push_back(mk(1,64'h504,0,0,0,0,0, 0,64'h400,0,0,0,0,1));
        tbl.push_back(mk(1,64'h504,1,64'h600,0,0,0, 1,64'h504,0,0,0,1,1));
        tbl.push_back(mk(1,64'h504,1,64'h600,1,64'h11111111_22222222,0, 1,64'h504,1,32'h11111111,0,1,1));
        tbl.push_back(mk(0,0,1,64'h600,0,0,0, 0,64'h504,0,0,0,1,1));
        tbl.push_back(mk(0,0,1,64'h600,1,64'h33334444_55556666,0, 1,64'h600,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,64'h600,0,0,0,0,0));

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            apply_row(tbl[i], i);
        end

        // Store: latched fields stay put while dreq inputs wander.
        @(posedge clk); #1;
        clear_inputs();
        dreq_valid = 1; dreq_write = 1; dreq_addr = 64'h700; dreq_size = 3'(MSIZE8);
        dreq_strobe = 8'h0F; dreq_wdata = 64'h1234;
        #1 check("store grant-cycle mreq_valid", mreq_valid, 0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            dreq_write = 0; dreq_addr = 64'hFFF0 + 64'(k); dreq_size = 3'(MSIZE1);
            dreq_strobe = 8'hF0; dreq_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
            mresp_valid = (k == 3); mresp_data = 64'h77;
            #1;
            check($sformatf("store%0d mreq_valid", k), mreq_valid, 1);
            check($sformatf("store%0d mreq_write", k), mreq_write, 1);
            check($sformatf("store%0d mreq_addr", k), mreq_addr, 64'h700);
            check($sformatf("store%0d mreq_strobe", k), mreq_strobe, 8'h0F);
            check($sformatf("store%0d mreq_wdata", k), mreq_wdata, 64'h1234);
            check($sformatf("store%0d mreq_size", k), mreq_size, 3'(MSIZE8));
            check($sformatf("store%0d dresp_valid", k), dresp_valid, (k == 3));
        end
        $display("store addr=0x700 strobe=0x0f wdata=0x1234 done");
        @(posedge clk); #1; clear_inputs(); #1;
        check("store after mreq_valid", mreq_valid, 0);

        // Watchdog: TIMEOUT busy cycles with no completion.
        @(posedge clk); #1;
        dreq_valid = 1; dreq_addr = 64'h800;
        #1 check("tmo grant mreq_valid", mreq_valid, 0);
        for (int k = 0; k < TIMEOUT; k++) begin
            @(posedge clk); #2;
            check($sformatf("tmo busy%0d mreq_valid", k), mreq_valid, 1);
            check($sformatf("tmo busy%0d dresp_valid", k), dresp_valid, 0);
            check($sformatf("tmo busy%0d bus_err", k), bus_err, 0);
        end
        @(posedge clk); #1; dreq_valid = 0; #1;
        check("tmo abort mreq_valid", mreq_valid, 0);
        check("tmo abort bus_err", bus_err, 1);
        check("tmo abort dresp_valid", dresp_valid, 0);
        $display("timeout addr=0x800 bus_err=%0b", bus_err);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1; mresp_valid = 1; #1;
            check($sformatf("tmo sticky%0d bus_err", k), bus_err, 1);
            check($sformatf("tmo sticky%0d dresp_valid", k), dresp_valid, 0);
        end

        // Reset in the middle of a data access.
        @(posedge clk); #1; clear_inputs(); dreq_valid = 1; dreq_addr = 64'h900; #1;
        @(posedge clk); #2;
        check("rst-mid mreq_valid before", mreq_valid, 1);
        check("rst-mid mreq_addr before", mreq_addr, 64'h900);
        #2;
        reset = 1; dreq_valid = 0; mresp_valid = 1; mresp_data = 64'h99;
        #1;
        check("rst-mid mreq_valid", mreq_valid, 0);
        check("rst-mid mreq_addr", mreq_addr, 0);
        check("rst-mid dresp_valid", dresp_valid, 0);
        check("rst-mid bus_err", bus_err, 0);
        check("rst-mid stall_all", stall_all, 0);
        repeat (2) @(negedge clk);
        reset = 0;
        @(posedge clk); #2;
        check("rst-after dresp_valid", dresp_valid, 0);
        check("rst-after mreq_valid", mreq_valid, 0);
        $display("reset mid-dmem addr=0x900 abandoned");
        @(posedge clk); #1; clear_inputs();

        // Randomized traffic against the reference model.
        model_reset();
        i_pend = 0; d_pend = 0; held_ia = '0;
        d_addr = '0; d_wdata = '0; d_wr = 0; d_size = '0; d_strb = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(posedge clk); #1;
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1; held_ia = {$urandom, $urandom} & ~64'h3;
            end
            if (!d_pend && $urandom_range(0, 5) == 0) begin
                d_pend = 1; d_addr = {$urandom, $urandom} & ~64'h7;
                d_wdata = {$urandom, $urandom}; d_wr = 1'($urandom);
                d_size = 3'($urandom_range(0, 3)); d_strb = 8'($urandom);
            end
            ireq_valid = i_pend; ireq_addr = held_ia;
            dreq_valid = d_pend; dreq_addr = d_addr; dreq_wdata = d_wdata;
            dreq_write = d_wr; dreq_size = d_size; dreq_strobe = d_strb;
            mresp_valid = ($urandom_range(0, 99) < 50);
            mresp_data = {$urandom, $urandom};
            flush = ($urandom_range(0, 9) == 0);
            #1;
            e_iv = (m_kind == 1) && mresp_valid && !m_dropped && !flush;
            e_dv = (m_kind == 2) && mresp_valid;
            e_sa = dreq_valid && !e_dv;
            e_sf = e_sa || (ireq_valid && !e_iv && !flush);
            check("rnd mreq_valid", mreq_valid, (m_kind != 0));
            check("rnd mreq_addr", mreq_addr, m_addr);
            check("rnd mreq_write", mreq_write, m_wr);
            check("rnd mreq_size", mreq_size, m_size);
            check("rnd mreq_strobe", mreq_strobe, m_strb);
            check("rnd mreq_wdata", mreq_wdata, m_wdata);
            check("rnd iresp_valid", iresp_valid, e_iv);
            if (e_iv) check("rnd iresp_data", iresp_data,
                            m_addr[2] ? mresp_data[63:32] : mresp_data[31:0]);
            check("rnd dresp_valid", dresp_valid, e_dv);
            if (e_dv) check("rnd dresp_rdata", dresp_rdata, mresp_data);
            check("rnd stall_all", stall_all, e_sa);
            check("rnd stall_fetch", stall_fetch, e_sf);
            check("rnd bus_err", bus_err, m_err);
            if (e_iv) $display("txn ifetch addr=0x%0h data=0x%08h", m_addr, iresp_data);
            if (e_dv) $display("txn dmem addr=0x%0h write=%0b rdata=0x%016h", m_addr, m_wr, dresp_rdata);
            model_step();
            if (e_iv || flush) i_pend = 0;
            if (e_dv) d_pend = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
